approx_error_sweeper: RTL and testbench

Sequential checker that exhaustively sweeps every input vector of an N_IN-input combinational circuit and compares an exact implementation against its approximate SOP counterpart. It computes the per-vector absolute output error and reports worst-case error, the violation count against a runtime error threshold, the first violating vector, and a pass/fail verdict. It sits between the exact/approximate circuit pair on the verification and characterisation path and sequences both circuits from one shared input counter.

---
 rtl/approx_chk_pkg.sv | 25 ++
 rtl/approx_err_accum.sv | 63 ++++++
 rtl/approx_error_sweeper.sv | 163 ++++++++++++++++
 tb/tb_approx_error_sweeper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_chk_pkg.sv
// Shared types and helpers for the exact-vs-approximate circuit sweeper.
// Widths up to MaxOutW bits go through abs_diff; callers size-cast in and out.
package approx_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain,
        StDone
    } state_t;

    localparam int unsigned MaxOutW = 16;
    localparam int unsigned DefNIn  = 4;
    localparam int unsigned NUM_VEC = 2 ** DefNIn;

    function automatic int unsigned num_vec(input int unsigned n_in);
        return 2 ** n_in;
    endfunction

    function automatic logic [MaxOutW-1:0] abs_diff(input logic [MaxOutW-1:0] a,
                                                     input logic [MaxOutW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Error statistics accumulator: worst-case error, violation count, first violator, verdict.
// clear has priority over a sample arriving in the same cycle.
module approx_err_accum
    import approx_chk_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [N_IN-1:0]  index,
    input  logic [N_OUT-1:0] err,
    input  logic [N_OUT-1:0] threshold,
    output logic [N_OUT-1:0] max_err,
    output logic [N_IN:0]    viol_cnt,
    output logic [N_IN-1:0]  first_viol_vec,
    output logic             pass
);

    localparam logic [N_IN:0] CntOne = 1;

    logic [N_OUT-1:0] max_q;
    logic [N_IN:0]    viol_q;
    logic [N_IN-1:0]  first_q;
    logic             pass_q;
    logic             found_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q   <= '0;
            viol_q  <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
            found_q <= 1'b0;
        end else if (clear) begin
            max_q   <= '0;
            viol_q  <= '0;
            first_q <= '0;
            pass_q  <= 1'b1;
            found_q <= 1'b0;
        end else if (valid) begin
            if (err > max_q) begin
                max_q <= err;
            end
            if (err > threshold) begin
                viol_q <= viol_q + CntOne;
                pass_q <= 1'b0;
                if (!found_q) begin
                    first_q <= index;
                    found_q <= 1'b1;
                end
            end
        end
    end

    assign max_err        = max_q;
    assign viol_cnt       = viol_q;
    assign first_viol_vec = first_q;
    assign pass           = pass_q;

endmodule

// File: rtl/approx_error_sweeper.sv
// Sweeps all 2^N_IN input vectors through an exact/approximate circuit pair and scores
// the absolute output error; a tag pipeline matches each returning sample to its vector.
module approx_error_sweeper
    import approx_chk_pkg::*;
#(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_OUT   = 3,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] et,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] exact_i,
    input  logic [N_OUT-1:0] approx_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] max_err,
    output logic [N_IN:0]    viol_cnt,
    output logic [N_IN-1:0]  first_viol_vec
);

    localparam logic [N_IN-1:0] VecOne    = 1;
    localparam logic [2:0]      DrainLast = 3'(DUT_LAT - 1);

    state_t           state_q;
    logic [N_IN-1:0]  vec_q;
    logic [2:0]       drain_q;
    logic [N_OUT-1:0] et_q;
    logic             busy_q;
    logic             done_q;

    logic             sweeping;
    logic             abort_hit;
    logic             accept;
    logic             tag_valid;
    logic [N_IN-1:0]  tag_index;
    logic             score_valid;
    logic [N_OUT-1:0] err;

    assign sweeping  = (state_q == StSweep);
    assign abort_hit = abort && (sweeping || state_q == StDrain);
    // abort beats start even in idle, so a simultaneous pair never launches a sweep
    assign accept    = (state_q == StIdle) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            drain_q <= '0;
            et_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StSweep;
                        vec_q   <= '0;
                        et_q    <= et;
                        busy_q  <= 1'b1;
                    end
                end
                StSweep: begin
                    if (abort_hit) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (vec_q == '1) begin
                        if (DUT_LAT > 0) begin
                            state_q <= StDrain;
                            drain_q <= '0;
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        vec_q <= vec_q + VecOne;
                    end
                end
                StDrain: begin
                    if (abort_hit) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (drain_q == DrainLast) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_no_lat
            assign tag_valid = sweeping;
            assign tag_index = vec_q;
        end else begin : g_lat
            logic [DUT_LAT-1:0] tag_v_q;
            logic [N_IN-1:0]    tag_idx_q [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_v_q <= '0;
                    for (int k = 0; k < DUT_LAT; k++) begin
                        tag_idx_q[k] <= '0;
                    end
                end else if (abort_hit || accept) begin
                    tag_v_q <= '0;
                end else begin
                    tag_v_q[0]   <= sweeping;
                    tag_idx_q[0] <= vec_q;
                    for (int k = 1; k < DUT_LAT; k++) begin
                        tag_v_q[k]   <= tag_v_q[k-1];
                        tag_idx_q[k] <= tag_idx_q[k-1];
                    end
                end
            end

            assign tag_valid = tag_v_q[DUT_LAT-1];
            assign tag_index = tag_idx_q[DUT_LAT-1];
        end
    endgenerate

    assign score_valid = tag_valid && !abort_hit;
    assign err = N_OUT'(abs_diff(MaxOutW'(exact_i), MaxOutW'(approx_i)));

    approx_err_accum #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_accum (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (accept),
        .valid          (score_valid),
        .index          (tag_index),
        .err            (err),
        .threshold      (et_q),
        .max_err        (max_err),
        .viol_cnt       (viol_cnt),
        .first_viol_vec (first_viol_vec),
        .pass           (pass)
    );

    assign vec_o = vec_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Bench for approx_error_sweeper: latency-0 and latency-2 instances side by side, circuits
// modelled as lookup tables, results checked against a plain-arithmetic sweep model.
module tb_approx_error_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] et;

    logic [2:0] lut_e [16];
    logic [2:0] lut_a [16];

    logic [3:0] vec0, vec2;
    logic [3:0] vd1 = '0;
    logic [3:0] vd2 = '0;
    logic [2:0] exact0, approx0, exact2, approx2;
    logic       busy0, done0, pass0, busy2, done2, pass2;
    logic [2:0] max0, max2;
    logic [4:0] cnt0, cnt2;
    logic [3:0] first0, first2;

    int checks = 0;
    int errors = 0;
    int exp_max, exp_cnt, exp_first, exp_pass;

    always #5 clk = ~clk;

    assign exact0  = lut_e[vec0];
    assign approx0 = lut_a[vec0];

    always @(posedge clk) begin
        vd1 <= vec2;
        vd2 <= vd1;
    end
    assign exact2  = lut_e[vd2];
    assign approx2 = lut_a[vd2];

    approx_error_sweeper #(.N_IN(4), .N_OUT(3), .DUT_LAT(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .et (et),
        .vec_o (vec0), .exact_i (exact0), .approx_i (approx0),
        .busy (busy0), .done (done0), .pass (pass0), .max_err (max0),
        .viol_cnt (cnt0), .first_viol_vec (first0)
    );

    approx_error_sweeper #(.N_IN(4), .N_OUT(3), .DUT_LAT(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .et (et),
        .vec_o (vec2), .exact_i (exact2), .approx_i (approx2),
        .busy (busy2), .done (done2), .pass (pass2), .max_err (max2),
        .viol_cnt (cnt2), .first_viol_vec (first2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_lut(input int mode);
        for (int v = 0; v < 16; v++) begin
            case (mode)
                0: begin lut_e[v] = 3'(v % 8); lut_a[v] = 3'(v % 8); end
                1: begin
                    lut_e[v] = 3'((v / 4 >= v % 4) ? (v / 4 - v % 4) : (v % 4 - v / 4));
                    lut_a[v] = 3'd0;
                end
                default: begin
                    lut_e[v] = 3'($urandom_range(0, 7));
                    lut_a[v] = 3'($urandom_range(0, 7));
                end
            endcase
        end
    endtask

    // Direct evaluation of the sweep statistics over all 16 vectors.
    task automatic model(input int thr);
        int e;
        exp_max = 0; exp_cnt = 0; exp_first = 0; exp_pass = 1;
        for (int v = 0; v < 16; v++) begin
            e = int'(lut_e[v]) - int'(lut_a[v]);
            if (e < 0) e = -e;
            if (e > exp_max) exp_max = e;
            if (e > thr) begin
                if (exp_cnt == 0) exp_first = v;
                exp_cnt++;
                exp_pass = 0;
            end
        end
    endtask

    task automatic begin_sweep(input int thr);
        @(posedge clk); #1;
        et = 3'(thr);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input int thr, input bit extra_starts, input string tag);
        int cyc;
        int d0;
        int d2;
        model(thr);
        begin_sweep(thr);
        cyc = 0; d0 = -1; d2 = -1;
        chk({tag, "_busy_c0"}, 32'(busy0), 1);
        chk({tag, "_vec_c0"}, 32'(vec0), 0);
        while (cyc < 40 && (d0 < 0 || d2 < 0)) begin
            if (done0 && d0 < 0) begin
                d0 = cyc;
                chk({tag, "_busy_at_done0"}, 32'(busy0), 0);
            end
            if (done2 && d2 < 0) begin
                d2 = cyc;
                chk({tag, "_busy_at_done2"}, 32'(busy2), 0);
            end
            if (cyc == 16 || cyc == 17) chk({tag, "_drain_vec"}, 32'(vec2), 15);
            start = extra_starts && (cyc == 3 || cyc == 16);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_cyc0"}, 32'(d0), 16);
        chk({tag, "_done_cyc2"}, 32'(d2), 18);
        chk({tag, "_busy_after"}, 32'(busy0), 0);
        chk({tag, "_pass0"}, 32'(pass0), 32'(exp_pass));
        chk({tag, "_max0"}, 32'(max0), 32'(exp_max));
        chk({tag, "_cnt0"}, 32'(cnt0), 32'(exp_cnt));
        chk({tag, "_first0"}, 32'(first0), 32'(exp_first));
        chk({tag, "_pass2"}, 32'(pass2), 32'(exp_pass));
        chk({tag, "_max2"}, 32'(max2), 32'(exp_max));
        chk({tag, "_cnt2"}, 32'(cnt2), 32'(exp_cnt));
        chk({tag, "_first2"}, 32'(first2), 32'(exp_first));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"}, 32'(vec0), 0);
        chk({tag, "_busy"}, 32'(busy0), 0);
        chk({tag, "_done"}, 32'(done0), 0);
        chk({tag, "_pass"}, 32'(pass0), 0);
        chk({tag, "_max"}, 32'(max0), 0);
        chk({tag, "_cnt"}, 32'(cnt0), 0);
        chk({tag, "_first"}, 32'(first0), 0);
        chk({tag, "_busy2"}, 32'(busy2), 0);
        chk({tag, "_cnt2"}, 32'(cnt2), 0);
        chk({tag, "_vec2"}, 32'(vec2), 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        et    = 3'd0;
        set_lut(0);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;

        set_lut(0);
        run(0, 1'b0, "identical");
        chk("identical_hw_pass", 32'(pass0), 1);
        set_lut(1);
        run(2, 1'b0, "absdiff_et2");
        chk("absdiff_et2_hw_first", 32'(first0), 3);
        chk("absdiff_et2_hw_cnt", 32'(cnt0), 2);
        run(3, 1'b0, "absdiff_et3");

        for (int r = 0; r < 4; r++) begin
            set_lut(2);
            run(int'($urandom_range(0, 7)), 1'b0, $sformatf("rand%0d", r));
        end

        // abort mid-sweep: no done, then a clean rerun
        set_lut(1);
        begin_sweep(2);
        repeat (5) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy0", 32'(busy0), 0);
        chk("abort_busy2", 32'(busy2), 0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (done0 || done2 || busy0 || busy2) seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(seen), 0);
        run(2, 1'b0, "after_abort");

        // abort and start together while idle
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_idle0", 32'(busy0), 0);
        chk("abort_start_idle2", 32'(busy2), 0);

        set_lut(2);
        run(1, 1'b1, "extra_starts");

        // reset mid-sweep
        set_lut(1);
        begin_sweep(0);
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_stay_idle", 32'(busy0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
